// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types: state/byte typedefs, the InvShiftRows/InvSubBytes FSM
// encoding, and a pure-wiring InvShiftRows helper.
package aes_pkg;

  localparam int AES_NBYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    ISS_IDLE = 2'd0,
    ISS_SUB  = 2'd1,
    ISS_DONE = 2'd2
  } iss_state_e;

  // Byte k sits at [127-8k -: 8] and s[r][c] is byte r+4c; row r rotates right by r.
  function automatic aes_state_t inv_shift_rows(aes_state_t s);
    logic [0:AES_NBYTES-1][7:0] b_in;
    logic [0:AES_NBYTES-1][7:0] b_out;
    b_in  = s;
    b_out = b_in;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        b_out[4'(r + 4 * c)] = b_in[4'(r + 4 * ((c - r + 4) % 4))];
      end
    end
    return b_out;
  endfunction

endpackage

// File: rtl/Inv_S_Box.sv
// Existing combinational AES inverse S-box lookup: B = InvSubBytes(A).
module Inv_S_Box (
  input  logic [7:0] A,
  output logic [7:0] B
);

  localparam logic [0:255][7:0] INV_TABLE = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign B = INV_TABLE[A];

endmodule

// File: rtl/inv_shift_sub_unit.sv
// Iterative InvShiftRows + InvSubBytes stage, SBOX_LANES bytes substituted per cycle.
// Define INV_SHIFT_SUB_ROWS_EN to apply InvShiftRows at capture; otherwise InvSubBytes only.
module inv_shift_sub_unit
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds data stable until then, and rst overrides any transfer on that edge.

  localparam int NGROUPS = AES_NBYTES / SBOX_LANES;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NGROUPS - 1);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("inv_shift_sub_unit: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  iss_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [0:AES_NBYTES-1][7:0] work_q, work_d;

  logic [3:0] lane_idx [SBOX_LANES];
  aes_byte_t  sbox_in  [SBOX_LANES];
  aes_byte_t  sbox_out [SBOX_LANES];

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    assign lane_idx[g] = 4'(int'(cnt_q) * SBOX_LANES + g);
    assign sbox_in[g]  = work_q[lane_idx[g]];
    Inv_S_Box u_inv_s_box (
      .A (sbox_in[g]),
      .B (sbox_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      ISS_IDLE: begin
        if (in_valid) begin
`ifdef INV_SHIFT_SUB_ROWS_EN
          work_d = inv_shift_rows(in_state);
`else
          work_d = in_state;
`endif
          cnt_d   = '0;
          state_d = ISS_SUB;
        end
      end
      ISS_SUB: begin
        for (int i = 0; i < SBOX_LANES; i++) begin
          work_d[lane_idx[i]] = sbox_out[i];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = ISS_DONE;
      end
      ISS_DONE: begin
        if (out_ready) state_d = ISS_IDLE;
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISS_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // out_state exposes the working register; only meaningful while out_valid is high.
  assign in_ready  = (state_q == ISS_IDLE);
  assign out_valid = (state_q == ISS_DONE);
  assign busy      = (state_q != ISS_IDLE);
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Directed bench for inv_shift_sub_unit: lane counts 4 (main), 1, 2, 8, 16 (sweep).
// Expected values come from constants and an S-box model derived from GF(2^8) arithmetic.
module tb_inv_shift_sub_unit;

  localparam int NDUT = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_state [NDUT];
  logic         busy      [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   inv_sbox [256];
  int exp_lat [NDUT] = '{4, 16, 8, 2, 1};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
    inv_shift_sub_unit #(.SBOX_LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(logic [7:0] x);
    logic [7:0] v = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(x, 8'(y)) == 8'h01) v = 8'(y);
      end
    end
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(logic [127:0] data);
    logic [0:15][7:0] b;
    logic [0:15][7:0] s;
    b = data;
    s = b;
`ifdef INV_SHIFT_SUB_ROWS_EN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[4'(r + 4 * c)] = b[4'(r + 4 * ((c + 4 - r) % 4))];
`endif
    for (int k = 0; k < 16; k++) s[k] = inv_sbox[s[k]];
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call at the negedge right after the accepting edge; returns cycles until out_valid.
  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check_eq("out_valid_timeout", 128'(out_valid[d]), 128'(1));
  endtask

  task automatic run_block(input int d, input logic [127:0] data,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    check_eq("idle_ready", 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_state[d] = data;
    @(negedge clk);
    in_valid[d] = 1'b0;
    wait_out(d, lat);
    res = out_state[d];
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_eq("post_hs_ready", 128'(in_ready[d]), 128'(1));
    check_eq("post_hs_valid", 128'(out_valid[d]), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] res;
    logic [127:0] exp_shift;
    logic [127:0] data;
    int lat;

    for (int x = 0; x < 256; x++) inv_sbox[sbox_fwd(8'(x))] = 8'(x);

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < NDUT; d++) begin
      check_eq("rst_in_ready",  128'(in_ready[d]),  128'(1));
      check_eq("rst_out_valid", 128'(out_valid[d]), 128'(0));
      check_eq("rst_busy",      128'(busy[d]),      128'(0));
      check_eq("rst_out_state", out_state[d],       128'h0);
    end

    // Directed vectors on the 4-lane unit
    run_block(0, 128'h0, res, lat);
    check_eq("zero_data", res, {16{8'h52}});
    check_eq("zero_lat", 128'(lat), 128'(4));
    run_block(0, {16{8'h63}}, res, lat);
    check_eq("x63_data", res, 128'h0);
    run_block(0, {16{8'hff}}, res, lat);
    check_eq("xff_data", res, {16{8'h7d}});
    run_block(0, {16{8'h01}}, res, lat);
    check_eq("x01_data", res, {16{8'h09}});

`ifdef INV_SHIFT_SUB_ROWS_EN
    exp_shift = 128'h52525252_52005252_52525252_52525252;
`else
    exp_shift = 128'h52005252_52525252_52525252_52525252;
`endif
    run_block(0, 128'h00630000_00000000_00000000_00000000, res, lat);
    check_eq("shift_data", res, exp_shift);

    // Backpressure: block A held in DONE while block B waits upstream
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = 128'h0;
    @(negedge clk);
    in_state[0] = {16{8'hff}};
    wait_out(0, lat);
    check_eq("bp_lat_a", 128'(lat), 128'(4));
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_stable",    out_state[0],          {16{8'h52}});
      check_eq("bp_no_accept", 128'(in_ready[0]),     128'(0));
      check_eq("bp_valid",     128'(out_valid[0]),    128'(1));
      check_eq("bp_busy",      128'(busy[0]),         128'(1));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check_eq("bp_release_ready", 128'(in_ready[0]),  128'(1));
    check_eq("bp_release_valid", 128'(out_valid[0]), 128'(0));
    @(negedge clk);
    in_valid[0] = 1'b0;
    check_eq("bp_b_accepted", 128'(busy[0]), 128'(1));
    wait_out(0, lat);
    check_eq("bp_b_data", out_state[0], {16{8'h7d}});
    check_eq("bp_b_lat", 128'(lat), 128'(4));
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset two edges after accept, mid-SUB
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = {16{8'hff}};
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check_eq("midrst_out_state", out_state[0],       128'h0);
    check_eq("midrst_in_ready",  128'(in_ready[0]),  128'(1));
    check_eq("midrst_busy",      128'(busy[0]),      128'(0));
    run_block(0, 128'h0, res, lat);
    check_eq("midrst_fresh_data", res, {16{8'h52}});
    check_eq("midrst_fresh_lat", 128'(lat), 128'(4));

    // Lane sweep with random blocks against the model
    for (int d = 1; d < NDUT; d++) begin
      for (int n = 0; n < 4; n++) begin
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_q.push_back(model(data));
        run_block(d, data, res, lat);
        check_eq("sweep_lat", 128'(lat), 128'(exp_lat[d]));
        check_eq("sweep_data", res, exp_q.pop_front());
      end
    end

    // Model cross-check on the 4-lane unit as well
    for (int n = 0; n < 4; n++) begin
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_q.push_back(model(data));
      run_block(0, data, res, lat);
      check_eq("rand4_data", res, exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
